time_entry_ctrl: RTL and testbench



---
 rtl/timer_pkg.sv | 17 +
 rtl/entry_shift_buf.sv | 31 +++
 rtl/time_entry_ctrl.sv | 122 ++++++++++++
 tb/tb_time_entry_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the microwave countdown front end: state encoding and
// BCD digit limits.
package timer_pkg;

    localparam int          DIGIT_W          = 4;
    localparam logic [3:0]  BCD_MAX          = 4'd9;
    localparam int          SEC_TENS_MAX_DEF = 5;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/entry_shift_buf.sv
// Keypad entry buffer: NDIGITS BCD digits, new digits enter at digit 0 and
// the top digit falls off. Flags an all-zero entry and legal seconds tens.
module entry_shift_buf
    import timer_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       shift,
    input  logic                       clr,
    input  logic [DIGIT_W-1:0]         din,
    output logic [DIGIT_W*NDIGITS-1:0] data,
    output logic                       is_zero,
    output logic                       sec_tens_ok
);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn)
            data <= '0;
        else if (clr)
            data <= '0;
        else if (shift)
            data <= {data[DIGIT_W*(NDIGITS-1)-1:0], din};
    end

    assign is_zero     = (data == '0);
    assign sec_tens_ok = (data[2*DIGIT_W-1:DIGIT_W] <= DIGIT_W'(SEC_TENS_MAX));

endmodule

// File: rtl/time_entry_ctrl.sv
// Microwave time-entry controller: gathers MM:SS keypad digits, loads them into
// the down-counting timer chain and gates its count enable from the 1 Hz tick.
module time_entry_ctrl
    import timer_pkg::*;
#(
    parameter int NDIGITS      = 4,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF
) (
    input  logic                       clk,
    input  logic                       clrn,
    input  logic                       digit_valid,
    input  logic [3:0]                 key_digit,
    input  logic                       start_p,
    input  logic                       stop_p,
    input  logic                       clear_p,
    input  logic                       door_open,
    input  logic                       tick_1hz,
    input  logic                       timer_zero,
    output logic [4*NDIGITS-1:0]       data_out,
    output logic                       loadn,
    output logic                       cnt_en,
    output logic                       running,
    output logic                       done,
    output logic                       err
);

    state_t state;
    logic   buf_shift;
    logic   buf_clr;
    logic   buf_zero;
    logic   buf_sec_ok;

    entry_shift_buf #(
        .NDIGITS      (NDIGITS),
        .SEC_TENS_MAX (SEC_TENS_MAX)
    ) u_buf (
        .clk         (clk),
        .clrn        (clrn),
        .shift       (buf_shift),
        .clr         (buf_clr),
        .din         (key_digit),
        .data        (data_out),
        .is_zero     (buf_zero),
        .sec_tens_ok (buf_sec_ok)
    );

    // Keys in IDLE resolve as clear > start > digit; the buffer is otherwise frozen.
    always_comb begin
        buf_shift = (state == ST_IDLE) && !clear_p && !start_p && digit_valid
                    && (key_digit <= BCD_MAX);
        buf_clr   = ((state == ST_IDLE) && clear_p)
                 || ((state == ST_PAUSE) && (stop_p || clear_p))
                 || (state == ST_DONE);
    end

    // Timers load only while enabled, so LOAD raises cnt_en alongside loadn=0.
    // In RUN the tick passes straight through so each tick decrements once.
    always_comb begin
        cnt_en = 1'b0;
        if (state == ST_LOAD)
            cnt_en = 1'b1;
        else if (state == ST_RUN)
            cnt_en = tick_1hz && !door_open && !timer_zero;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state   <= ST_IDLE;
            loadn   <= 1'b1;
            running <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!clear_p && start_p && !buf_zero) begin
                        if (!buf_sec_ok) begin
                            err <= 1'b1;
                        end else begin
                            state <= ST_LOAD;
                            loadn <= 1'b0;
                        end
                    end
                end
                ST_LOAD: begin
                    state   <= ST_RUN;
                    loadn   <= 1'b1;
                    running <= 1'b1;
                end
                ST_RUN: begin
                    if (timer_zero) begin
                        state   <= ST_DONE;
                        running <= 1'b0;
                        done    <= 1'b1;
                    end else if (stop_p) begin
                        state   <= ST_PAUSE;
                        running <= 1'b0;
                    end
                end
                ST_PAUSE: begin
                    if (stop_p || clear_p) begin
                        state <= ST_IDLE;
                    end else if (start_p && !door_open) begin
                        state   <= ST_RUN;
                        running <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state   <= ST_IDLE;
                    loadn   <= 1'b1;
                    running <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_time_entry_ctrl.sv
// Directed bench for time_entry_ctrl: entry, load, run/pause, completion,
// rejected starts and asynchronous reset.
module tb_time_entry_ctrl;

    logic        clk = 1'b0;
    logic        clrn;
    logic        digit_valid;
    logic [3:0]  key_digit;
    logic        start_p;
    logic        stop_p;
    logic        clear_p;
    logic        door_open;
    logic        tick_1hz;
    logic        timer_zero;
    logic [15:0] data_out;
    logic        loadn;
    logic        cnt_en;
    logic        running;
    logic        done;
    logic        err;

    int n_vec  = 0;
    int n_fail = 0;

    time_entry_ctrl #(.NDIGITS(4), .SEC_TENS_MAX(5)) dut (
        .clk         (clk),
        .clrn        (clrn),
        .digit_valid (digit_valid),
        .key_digit   (key_digit),
        .start_p     (start_p),
        .stop_p      (stop_p),
        .clear_p     (clear_p),
        .door_open   (door_open),
        .tick_1hz    (tick_1hz),
        .timer_zero  (timer_zero),
        .data_out    (data_out),
        .loadn       (loadn),
        .cnt_en      (cnt_en),
        .running     (running),
        .done        (done),
        .err         (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit_valid = 1'b1;
        key_digit   = d;
        cyc();
        digit_valid = 1'b0;
        key_digit   = 4'd0;
    endtask

    task automatic pulse_start();
        start_p = 1'b1;
        cyc();
        start_p = 1'b0;
    endtask

    task automatic pulse_stop();
        stop_p = 1'b1;
        cyc();
        stop_p = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_p = 1'b1;
        cyc();
        clear_p = 1'b0;
    endtask

    initial begin
        clrn = 1'b0; digit_valid = 1'b0; key_digit = 4'd0; start_p = 1'b0;
        stop_p = 1'b0; clear_p = 1'b0; door_open = 1'b0; tick_1hz = 1'b0;
        timer_zero = 1'b0;
        cyc(); cyc();
        chk("rst_data", data_out, 16'h0000);
        chk("rst_loadn", {15'd0, loadn}, 16'd1);
        chk("rst_cnt_en", {15'd0, cnt_en}, 16'd0);
        chk("rst_running", {15'd0, running}, 16'd0);
        chk("rst_done_err", {14'd0, done, err}, 16'd0);
        clrn = 1'b1;
        cyc();

        // entry 1,3,0 then load
        press(4'd1); press(4'd3); press(4'd0);
        chk("entry_0130", data_out, 16'h0130);
        pulse_start();
        chk("load_loadn", {15'd0, loadn}, 16'd0);
        chk("load_cnt_en", {15'd0, cnt_en}, 16'd1);
        chk("load_running", {15'd0, running}, 16'd0);
        chk("load_data", data_out, 16'h0130);
        cyc();
        chk("run_running", {15'd0, running}, 16'd1);
        chk("run_loadn", {15'd0, loadn}, 16'd1);
        chk("run_cnt_en_idle", {15'd0, cnt_en}, 16'd0);

        // ticks every 10 cycles, door open for ticks 1..3
        for (int k = 0; k < 6; k++) begin
            repeat (9) cyc();
            door_open = (k >= 1 && k <= 3);
            tick_1hz  = 1'b1;
            #1;
            chk($sformatf("tick%0d_cnt_en", k), {15'd0, cnt_en}, (k >= 1 && k <= 3) ? 16'd0 : 16'd1);
            cyc();
            tick_1hz  = 1'b0;
            door_open = 1'b0;
            chk($sformatf("tick%0d_running", k), {15'd0, running}, 16'd1);
        end
        press(4'd7);
        chk("run_digit_ignored", data_out, 16'h0130);
        pulse_clear();
        chk("run_clear_ignored", data_out, 16'h0130);

        // asynchronous reset mid-RUN
        clrn = 1'b0;
        cyc();
        tick_1hz = 1'b1;
        #1;
        chk("mid_rst_data", data_out, 16'h0000);
        chk("mid_rst_loadn", {15'd0, loadn}, 16'd1);
        chk("mid_rst_cnt_en", {15'd0, cnt_en}, 16'd0);
        chk("mid_rst_running", {15'd0, running}, 16'd0);
        tick_1hz = 1'b0;
        clrn = 1'b1;
        cyc();

        // 5 digits plus an illegal 0xA key
        press(4'd1); press(4'd2); press(4'd3); press(4'd4); press(4'd5); press(4'hA);
        chk("entry_2345", data_out, 16'h2345);
        pulse_clear();
        chk("clear_buf", data_out, 16'h0000);
        pulse_start();
        chk("zero_start_loadn", {15'd0, loadn}, 16'd1);
        chk("zero_start_err", {15'd0, err}, 16'd0);

        // illegal seconds tens
        press(4'd7); press(4'd0);
        chk("entry_0070", data_out, 16'h0070);
        pulse_start();
        chk("bad_start_err", {15'd0, err}, 16'd1);
        chk("bad_start_loadn", {15'd0, loadn}, 16'd1);
        cyc();
        chk("bad_start_err_off", {15'd0, err}, 16'd0);
        chk("bad_start_running", {15'd0, running}, 16'd0);
        chk("bad_start_data", data_out, 16'h0070);

        // clear beats start in the same cycle
        clear_p = 1'b1; start_p = 1'b1;
        cyc();
        clear_p = 1'b0; start_p = 1'b0;
        chk("clr_vs_start_loadn", {15'd0, loadn}, 16'd1);
        chk("clr_vs_start_data", data_out, 16'h0000);

        // completion: zero flag with tick in the same cycle
        press(4'd1); press(4'd0);
        pulse_start(); cyc();
        chk("run2_running", {15'd0, running}, 16'd1);
        tick_1hz = 1'b1; timer_zero = 1'b1;
        #1;
        chk("zero_cnt_en", {15'd0, cnt_en}, 16'd0);
        cyc();
        tick_1hz = 1'b0; timer_zero = 1'b0;
        chk("done_pulse", {15'd0, done}, 16'd1);
        chk("done_running", {15'd0, running}, 16'd0);
        cyc();
        chk("done_off", {15'd0, done}, 16'd0);
        chk("done_data_clr", data_out, 16'h0000);
        press(4'd4);
        chk("idle_after_done", data_out, 16'h0004);

        // pause / resume / cancel
        pulse_start(); cyc();
        chk("run3_running", {15'd0, running}, 16'd1);
        pulse_stop();
        chk("pause_running", {15'd0, running}, 16'd0);
        tick_1hz = 1'b1;
        #1;
        chk("pause_cnt_en", {15'd0, cnt_en}, 16'd0);
        tick_1hz = 1'b0;
        door_open = 1'b1;
        pulse_start();
        door_open = 1'b0;
        chk("pause_door_start", {15'd0, running}, 16'd0);
        pulse_start();
        chk("resume_running", {15'd0, running}, 16'd1);
        pulse_stop();
        chk("pause2_running", {15'd0, running}, 16'd0);
        chk("pause2_data", data_out, 16'h0004);
        pulse_stop();
        chk("cancel_data", data_out, 16'h0000);
        press(4'd5);
        chk("idle_after_cancel", data_out, 16'h0005);

        // seconds tens at the legal limit is accepted
        pulse_clear();
        press(4'd5); press(4'd9);
        pulse_start();
        chk("limit_loadn", {15'd0, loadn}, 16'd0);
        chk("limit_err", {15'd0, err}, 16'd0);
        chk("limit_data", data_out, 16'h0059);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
